// File: rtl/bcd_seg7_scanner_pkg.sv
// Shared segment codes, scan FSM state encoding and anode helpers for the 7-segment scanner.
package bcd_seg7_scanner_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] DIGITS_OFF = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  // Active-low anode enable for one digit position.
  function automatic logic [3:0] anode_n(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_seg7_scanner_if.sv
// Count-bus capture inputs and display drive outputs of the 7-segment scanner.
interface bcd_seg7_scanner_if;
  logic [15:0] BcdIn;
  logic        BcdValid;
  logic [3:0]  DpIn;
  logic [6:0]  Seg;
  logic        Dp;
  logic [3:0]  Digit;
  logic        BcdErr;

  modport master (
    output BcdIn, BcdValid, DpIn,
    input  Seg, Dp, Digit, BcdErr
  );

  modport slave (
    input  BcdIn, BcdValid, DpIn,
    output Seg, Dp, Digit, BcdErr
  );
endinterface

// File: rtl/bcd_seg7_scanner_bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import bcd_seg7_scanner_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o,
  output logic       invalid_o
);

  always_comb begin
    seg_o     = SEG_DASH;
    invalid_o = 1'b0;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: begin
        seg_o     = SEG_DASH;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment scanner with frame-synchronous value update.
// Optional leading-zero blanking is built when SEG7_LZ_BLANK_EN is defined.
//
// state    | meaning
// ST_BLANK | slot lead-in, all anodes off to avoid ghosting
// ST_ON    | digit idx lit with its decoded segments
module bcd_seg7_scanner
  import bcd_seg7_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic Clk,
  input  logic Reset,
  bcd_seg7_scanner_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

  scan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;

  logic [15:0]      pending_q;
  logic [3:0]       pend_dp_q;
  logic             pending_flag_q;

  // Display holds decoded patterns so a transfer needs no decode on the scan path.
  logic [6:0]       disp_seg_q [4];
  logic [3:0]       disp_dp_q;
  logic             err_q;

  logic [3:0]       digit_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic [6:0]       pend_seg [4];
  logic [3:0]       pend_inv;

  logic             frame_wrap;
  logic             lz_dark;
  logic [3:0]       digit_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    bcd_to_seg7 u_dec (
      .nibble_i  (pending_q[4*g +: 4]),
      .seg_o     (pend_seg[g]),
      .invalid_o (pend_inv[g])
    );
  end

  assign frame_wrap = (state_q == ST_ON) && (cnt_q == ON_LAST) && (idx_q == 2'd3);

  always_comb begin
    lz_dark = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    // Dark when this and every more-significant digit is zero and no point is requested here.
    lz_dark = (idx_q != 2'd0) && !disp_dp_q[idx_q];
    for (int k = 1; k < 4; k++) begin
      if ((k >= int'(idx_q)) && (disp_seg_q[k] != SEG_0)) begin
        lz_dark = 1'b0;
      end
    end
`endif
    digit_d = DIGITS_OFF;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    if ((state_q == ST_ON) && !lz_dark) begin
      digit_d = anode_n(idx_q);
      seg_d   = disp_seg_q[idx_q];
      dp_d    = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= ST_BLANK;
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      pending_q      <= '0;
      pend_dp_q      <= '0;
      pending_flag_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        disp_seg_q[k] <= SEG_0;
      end
      disp_dp_q      <= '0;
      err_q          <= 1'b0;
      digit_q        <= DIGITS_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= 1'b1;
    end else begin
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;

      if (state_q == ST_BLANK) begin
        if (cnt_q == BLANK_LAST) begin
          state_q <= ST_ON;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == ON_LAST) begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
          idx_q   <= idx_q + 2'd1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      if (frame_wrap && pending_flag_q) begin
        disp_seg_q     <= pend_seg;
        disp_dp_q      <= pend_dp_q;
        err_q          <= err_q | (|pend_inv);
        pending_flag_q <= 1'b0;
      end

      // A strobe coinciding with the transfer re-arms pending for the next frame.
      if (bus.BcdValid) begin
        pending_q      <= bus.BcdIn;
        pend_dp_q      <= bus.DpIn;
        pending_flag_q <= 1'b1;
      end
    end
  end

  assign bus.Digit  = digit_q;
  assign bus.Seg    = seg_q;
  assign bus.Dp     = dp_q;
  assign bus.BcdErr = err_q;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Directed bench for bcd_seg7_scanner with SCAN_DIV=8, BLANK_CYCLES=2 (32-cycle frames).
module tb_bcd_seg7_scanner;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   vectors;
  int   miscompares;

  bcd_seg7_scanner_if bus_if ();

  bcd_seg7_scanner #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] d, input logic [6:0] s, input logic p);
    vectors++;
    assert (bus_if.Digit === d)
    else begin
      miscompares++;
      $error("FAIL %s Digit: observed %h expected %h", tag, bus_if.Digit, d);
    end
    vectors++;
    assert (bus_if.Seg === s)
    else begin
      miscompares++;
      $error("FAIL %s Seg: observed %h expected %h", tag, bus_if.Seg, s);
    end
    vectors++;
    assert (bus_if.Dp === p)
    else begin
      miscompares++;
      $error("FAIL %s Dp: observed %b expected %b", tag, bus_if.Dp, p);
    end
  endtask

  task automatic expect_err(input string tag, input logic e);
    vectors++;
    assert (bus_if.BcdErr === e)
    else begin
      miscompares++;
      $error("FAIL %s BcdErr: observed %b expected %b", tag, bus_if.BcdErr, e);
    end
  endtask

  // One 8-cycle slot: 2 blank outputs then 6 lit outputs; optional strobe at position spos.
  task automatic slot(input string tag, input logic [3:0] dig, input logic [6:0] seg,
                      input logic dp, input bit lzd, input int spos,
                      input logic [15:0] sbcd, input logic [3:0] sdp);
    for (int p = 0; p < 8; p++) begin
      if (p == spos) begin
        bus_if.BcdIn    = sbcd;
        bus_if.DpIn     = sdp;
        bus_if.BcdValid = 1'b1;
      end
      step();
      bus_if.BcdValid = 1'b0;
      if (p < 2 || (LZ && lzd)) expect_out($sformatf("%s p%0d", tag, p), 4'hF, 7'h7F, 1'b1);
      else                      expect_out($sformatf("%s p%0d", tag, p), dig, seg, dp);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    Reset           = 1'b0;
    bus_if.BcdIn    = 16'h0;
    bus_if.DpIn     = 4'h0;
    bus_if.BcdValid = 1'b0;

    repeat (3) step();
    expect_out("reset", 4'hF, 7'h7F, 1'b1);
    expect_err("reset", 1'b0);
    Reset = 1'b1;

    // Frame 0: default "0000"
    slot("f0u", 4'hE, 7'h40, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f0t", 4'hD, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("f0h", 4'hB, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("f0k", 4'h7, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    expect_err("f0", 1'b0);

    // Frame 1: capture 1234 mid-frame, display unchanged
    slot("f1u", 4'hE, 7'h40, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f1t", 4'hD, 7'h40, 1'b1, 1'b1, 3, 16'h1234, 4'b0100);
    slot("f1h", 4'hB, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("f1k", 4'h7, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);

    // Frame 2: "1234" with hundreds point; capture 12A4
    slot("f2u", 4'hE, 7'h19, 1'b1, 1'b0, 4, 16'h12A4, 4'b0000);
    slot("f2t", 4'hD, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f2h", 4'hB, 7'h24, 1'b0, 1'b0, -1, 16'h0, 4'h0);
    expect_err("f2 before transfer", 1'b0);
    slot("f2k", 4'h7, 7'h79, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    expect_err("f2 transfer edge", 1'b1);

    // Frame 3: "12A4" shows a dash in tens; capture 0001
    slot("f3u", 4'hE, 7'h19, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f3t", 4'hD, 7'h3F, 1'b1, 1'b0, 2, 16'h0001, 4'b0000);
    slot("f3h", 4'hB, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f3k", 4'h7, 7'h79, 1'b1, 1'b0, -1, 16'h0, 4'h0);

    // Frame 4: "0001", error sticky; strobes 1111 then 2222
    slot("f4u", 4'hE, 7'h79, 1'b1, 1'b0, 3, 16'h1111, 4'b0000);
    slot("f4t", 4'hD, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("f4h", 4'hB, 7'h40, 1'b1, 1'b1, 5, 16'h2222, 4'b0000);
    slot("f4k", 4'h7, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    expect_err("f4 sticky", 1'b1);

    // Frame 5: "2222"; capture 3333, then 5555 exactly on the transfer edge
    slot("f5u", 4'hE, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f5t", 4'hD, 7'h24, 1'b1, 1'b0, 4, 16'h3333, 4'b0000);
    slot("f5h", 4'hB, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f5k", 4'h7, 7'h24, 1'b1, 1'b0, 7, 16'h5555, 4'b0000);

    // Frame 6: "3333"; frame 7: "5555"
    slot("f6u", 4'hE, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f6t", 4'hD, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f6h", 4'hB, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f6k", 4'h7, 7'h30, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f7u", 4'hE, 7'h12, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f7t", 4'hD, 7'h12, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f7h", 4'hB, 7'h12, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("f7k", 4'h7, 7'h12, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    expect_err("f7 sticky", 1'b1);

    // Reset asserted in the middle of an ON slot
    repeat (4) step();
    expect_out("pre-reset lit", 4'hE, 7'h12, 1'b1);
    Reset = 1'b0;
    #1;
    expect_out("async reset", 4'hF, 7'h7F, 1'b1);
    expect_err("async reset", 1'b0);
    repeat (2) step();
    Reset = 1'b1;

    // Restart at units with the blank gap; then capture 0042
    slot("r0u", 4'hE, 7'h40, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("r0t", 4'hD, 7'h40, 1'b1, 1'b1, 2, 16'h0042, 4'b0000);
    slot("r0h", 4'hB, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("r0k", 4'h7, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("r1u", 4'hE, 7'h24, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("r1t", 4'hD, 7'h19, 1'b1, 1'b0, -1, 16'h0, 4'h0);
    slot("r1h", 4'hB, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    slot("r1k", 4'h7, 7'h40, 1'b1, 1'b1, -1, 16'h0, 4'h0);
    expect_err("r1", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_seg7_scanner.md
Name: bcd_seg7_scanner

Overview:
- Reader side of the 16-bit BCD count bus: captures a 4-digit packed BCD word and drives a time-multiplexed, common-anode 4-digit 7-segment display on the AlchitryAu+ IO board.
- Sits downstream of the BCD counter. Scans one digit per slot, with a blanking gap between slots to prevent ghosting.
- Updates the displayed value only at frame boundaries, so no tearing.
- Flags non-BCD nibbles.

Parameters:
- SCAN_DIV, 100000: Clk cycles per digit slot, including blank (1 kHz/digit at 100 MHz). Must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all digits off. Must be ≥1.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- BcdIn  in  16  packed BCD; [3:0] = units (rightmost), [15:12] = thousands
- BcdValid  in  1  capture strobe; BcdIn/DpIn sampled on any rising Clk edge where high
- DpIn  in  4  decimal-point request per digit, 1 = lit
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- Dp  out  1  decimal point, active-low
- Digit  out  4  anode enables, active-low; Digit[0] = units
- BcdErr  out  1  sticky: a displayed nibble was > 9

Behaviour:
- Reset (async, Reset=0):
  - Digit=4'hF, Seg=7'h7F, Dp=1, BcdErr=0.
  - pending, display and pending_flag cleared.
  - idx=0, slot counter=0, state=BLANK.
- Capture:
  - BcdValid=1 → pending<=BcdIn, pend_dp<=DpIn, pending_flag<=1.
  - Later strobes overwrite pending; last one wins.
- Frame transfer:
  - Occurs on the cycle the FSM enters BLANK with idx wrapping 3→0, and only if pending_flag=1.
  - display<=pending, disp_dp<=pend_dp, pending_flag<=0.
  - A BcdValid on that same cycle lands in pending and sets pending_flag again; transfer uses the old pending.
- FSM, 2 states; counter width $clog2(SCAN_DIV):
  - BLANK: Digit=4'hF, Seg=7'h7F, Dp=1. After BLANK_CYCLES cycles → ON.
  - ON: Digit[idx]=0, others 1. Seg=decode(display nibble idx), Dp=~disp_dp[idx]. After SCAN_DIV−BLANK_CYCLES cycles → BLANK, idx<=idx+1 mod 4.
  - Frame = 4×SCAN_DIV cycles. Slot order: 0,1,2,3.
  - All outputs registered; state changes appear on outputs 1 cycle after the deciding edge.
- Decode (active-low, hex {g..a}): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; A–F → dash 3F.
- BcdErr:
  - Set on the transfer cycle if any transferred nibble > 9.
  - Cleared only by Reset.
- Before the first transfer, display=0 and shows "0000".
- Reset mid-slot: outputs blank immediately (async); scanning restarts at idx 0 in BLANK.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - In slot k (k=3..1), the digit is kept dark (Digit=4'hF, Seg=7'h7F) if display nibbles k..3 are all 0 and disp_dp[k]=0.
  - Digit 0 is always shown. Timing is unchanged.
- Undefined: all four digits always shown.

Decomposition:
- Shared include seg7_defs.vh:
  - SEG_0..SEG_9, SEG_DASH, SEG_OFF constants.
  - FSM state encodings ST_BLANK/ST_ON.
  - DIGITS_OFF constant.
- Sub-module bcd_to_seg7: combinational, 4-bit nibble in → 7-bit active-low segments + invalid flag.
  - Reused by the scanner and for the transfer-time BcdErr check (4 instances, or shared via muxing).

Test Plan (bench uses SCAN_DIV=8, BLANK_CYCLES=2):
- Release Reset, no BcdValid → Digit cycles E,D,B,7 with 2-cycle 4'hF gaps, Seg=40 in every ON slot, frame=32 cycles, BcdErr=0.
- BcdValid with BcdIn=16'h1234, DpIn=4'b0100 mid-frame:
  - Display remains "0000" until the next idx 3→0 wrap.
  - Then units slot Seg=19 (4), tens 30 (3), hundreds 24 (2) with Dp=0, thousands 79 (1).
- BcdIn=16'h12A4 captured:
  - Tens slot shows Seg=3F.
  - BcdErr rises on the transfer cycle and stays 1 after a later valid 16'h0001.
- Strobes 16'h1111 then 16'h2222 within one frame → only "2222" displayed next frame; "1111" never appears.
- BcdValid=16'h5555 exactly on the transfer cycle, with pending=16'h3333 → next frame shows 3333, following frame shows 5555.
- Assert Reset during an ON slot → Digit=4'hF and Seg=7'h7F immediately. After release, scanning restarts at units with the BLANK gap. With SEG7_LZ_BLANK_EN, value 16'h0042 leaves slots 2 and 3 dark.
